// File: rtl/decimal_answer_formatter_if.sv
// Answer input pulse pair plus byte valid/ready stream toward the UART transmitter.
// slave: formatter side; master: producer/consumer side (testbench or parent).
interface decimal_answer_formatter_if #(
  parameter int ANSWER_BIT_WIDTH = 24
);
  logic                        new_data;
  logic [ANSWER_BIT_WIDTH-1:0] data;
  logic                        byte_ready;
  logic                        byte_valid;
  logic [7:0]                  byte_data;
  logic                        busy;
  logic                        overrun;

  modport slave (
    input  new_data,
    input  data,
    input  byte_ready,
    output byte_valid,
    output byte_data,
    output busy,
    output overrun
  );

  modport master (
    output new_data,
    output data,
    output byte_ready,
    input  byte_valid,
    input  byte_data,
    input  busy,
    input  overrun
  );
endinterface

// File: rtl/decimal_answer_formatter.sv
// Binary answer -> decimal ASCII line (MSD first, no leading zeros, CR LF); first byte ANSWER_BIT_WIDTH+z+2 cycles after new_data.
// byte_valid holds with stable byte_data until byte_ready; one pending answer is buffered, newest overwrites it.
module decimal_answer_formatter #(
  parameter int ANSWER_BIT_WIDTH = 24,
  parameter int DIGITS           = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  decimal_answer_formatter_if.slave   io
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONVERT = 3'd1;
  localparam logic [2:0] S_SKIP    = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_CR      = 3'd4;
  localparam logic [2:0] S_LF      = 3'd5;

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(ANSWER_BIT_WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ANSWER_BIT_WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSD  = IDX_W'(DIGITS - 1);

  logic [2:0]                  state_q, state_d;
  logic [ANSWER_BIT_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]            bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        pend_vld_q, pend_vld_d;
  logic [ANSWER_BIT_WIDTH-1:0] pend_dat_q, pend_dat_d;
  logic                        overrun_q, overrun_d;
  logic                        byte_valid_q, byte_valid_d;
  logic [7:0]                  byte_data_q, byte_data_d;
  logic                        busy_q, busy_d;
  logic                        xfer;
  logic [3:0]                  cur_digit;

  assign xfer      = byte_valid_q && io.byte_ready;
  assign cur_digit = bcd_q[{idx_q, 2'b00} +: 4];

  // Double-dabble correction step applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    overrun_d  = 1'b0;

    if (state_q != S_IDLE && io.new_data) begin
      pend_vld_d = 1'b1;
      pend_dat_d = io.data;
      overrun_d  = pend_vld_q;
    end

    case (state_q)
      S_IDLE: begin
        if (io.new_data) begin
          shift_d = io.data;
          bcd_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[ANSWER_BIT_WIDTH-1]};
        shift_d = {shift_q[ANSWER_BIT_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_SKIP;
          idx_d   = IDX_MSD;
        end
      end
      S_SKIP: begin
        if (cur_digit == 4'd0 && idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (xfer) begin
          if (idx_q == '0) begin
            state_d = S_CR;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      S_CR: begin
        if (xfer) begin
          state_d = S_LF;
        end
      end
      S_LF: begin
        if (xfer) begin
          // A consumed pending slot cannot overrun; a same-cycle answer refills it.
          if (pend_vld_q) begin
            shift_d    = pend_dat_q;
            pend_vld_d = io.new_data;
            pend_dat_d = io.new_data ? io.data : pend_dat_q;
            overrun_d  = 1'b0;
            bcd_d      = '0;
            cnt_d      = CNT_LOAD;
            state_d    = S_CONVERT;
          end else if (io.new_data) begin
            shift_d    = io.data;
            pend_vld_d = 1'b0;
            overrun_d  = 1'b0;
            bcd_d      = '0;
            cnt_d      = CNT_LOAD;
            state_d    = S_CONVERT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they change only on clock edges.
  always_comb begin
    byte_valid_d = (state_d == S_EMIT) || (state_d == S_CR) || (state_d == S_LF);
    busy_d       = (state_d != S_IDLE);
    case (state_d)
      S_EMIT:  byte_data_d = {4'h3, bcd_q[{idx_d, 2'b00} +: 4]};
      S_CR:    byte_data_d = 8'h0D;
      S_LF:    byte_data_d = 8'h0A;
      default: byte_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_vld_q   <= 1'b0;
      pend_dat_q   <= '0;
      overrun_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_vld_q   <= pend_vld_d;
      pend_dat_q   <= pend_dat_d;
      overrun_q    <= overrun_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      busy_q       <= busy_d;
    end
  end

  assign io.byte_valid = byte_valid_q;
  assign io.byte_data  = byte_data_q;
  assign io.busy       = busy_q;
  assign io.overrun    = overrun_q;

endmodule

// File: tb/tb_decimal_answer_formatter.sv
// Bench for decimal_answer_formatter: table of single answers, hand-built corner sequences, random traffic vs a line-level model.
module tb_decimal_answer_formatter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  decimal_answer_formatter_if #(.ANSWER_BIT_WIDTH(24)) io ();

  decimal_answer_formatter #(.ANSWER_BIT_WIDTH(24), .DIGITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Line-level reference model: expected byte stream, busy flag, one pending slot.
  logic [7:0]  m_q[$];
  logic        m_busy;
  logic        m_pend_vld;
  logic [23:0] m_pend;
  logic        m_ovr;
  logic        hold_vld;
  logic [7:0]  hold_dat;
  logic [7:0]  got[$];
  int          ovr_cnt;
  int          last_xfer_cyc;

  typedef struct packed {
    logic [23:0] data;
    logic [7:0]  first_cyc;
    logic [63:0] txt;
    logic [3:0]  len;
    logic        slow;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy     = 1'b0;
    m_pend_vld = 1'b0;
    m_pend     = '0;
    m_ovr      = 1'b0;
    hold_vld   = 1'b0;
    hold_dat   = '0;
  endtask

  task automatic start_line(input logic [23:0] v);
    int t;
    logic [7:0] ds[$];
    t = int'(v);
    do begin
      ds.push_front(8'(8'h30 + t % 10));
      t = t / 10;
    end while (t > 0);
    foreach (ds[i]) m_q.push_back(ds[i]);
    m_q.push_back(8'h0D);
    m_q.push_back(8'h0A);
    m_busy = 1'b1;
  endtask

  // One clock cycle: check this cycle's outputs, drive inputs, advance model, step the clock.
  task automatic step(input logic nd, input logic [23:0] d, input logic rdy);
    logic       xfer;
    logic [7:0] eb;
    chk("busy", io.busy, m_busy);
    chk("overrun", io.overrun, m_ovr);
    if (hold_vld) begin
      chk("valid_held", io.byte_valid, 1);
      chk("data_held", io.byte_data, hold_dat);
    end
    if (io.overrun) ovr_cnt++;
    io.new_data   = nd;
    io.data       = d;
    io.byte_ready = rdy;
    xfer  = io.byte_valid && rdy;
    m_ovr = 1'b0;
    if (xfer) begin
      got.push_back(io.byte_data);
      last_xfer_cyc = cyc;
      if (m_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_byte actual=%02h required=none", io.byte_data);
      end else begin
        eb = m_q.pop_front();
        chk("byte", io.byte_data, eb);
        if (eb == 8'h0A) begin
          if (m_pend_vld) begin
            start_line(m_pend);
            m_pend_vld = 1'b0;
          end else begin
            m_busy = 1'b0;
          end
        end
      end
    end
    if (nd) begin
      if (!m_busy) begin
        start_line(d);
      end else begin
        if (m_pend_vld) m_ovr = 1'b1;
        m_pend     = d;
        m_pend_vld = 1'b1;
      end
    end
    hold_vld = io.byte_valid && !rdy;
    hold_dat = io.byte_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input int maxc);
    for (int k = 0; k < maxc && io.busy; k++) step(1'b0, 24'd0, 1'b1);
    chk("drain_idle", io.busy, 0);
  endtask

  task automatic chk_got(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) chk(name, got[i], exp[i]);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          c0;
    int          first;
    int          n;
    logic        done;
    logic        rdy;
    logic [63:0] t;
    got.delete();
    n     = int'(v.len);
    t     = v.txt;
    first = -1;
    done  = 1'b0;
    c0    = cyc;
    step(1'b1, v.data, 1'b1);
    for (int k = 0; k < 300 && !done; k++) begin
      if (io.byte_valid && first < 0) first = cyc - c0;
      rdy  = v.slow ? (cyc % 3 == 0) : 1'b1;
      done = io.byte_valid && rdy && (io.byte_data == 8'h0A);
      step(1'b0, 24'd0, rdy);
    end
    chk("line_done", done, 1);
    chk("first_byte_cycle", first, int'(v.first_cyc));
    if (!v.slow) chk("line_cycles", last_xfer_cyc - (c0 + first), n + 1);
    chk("line_len", got.size(), n + 2);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) chk("digit", got[i], t[8*(n-1-i) +: 8]);
    end
    if (got.size() == n + 2) begin
      chk("cr", got[n], 8'h0D);
      chk("lf", got[n+1], 8'h0A);
    end
    chk("busy_after_lf", io.busy, 0);
  endtask

  initial begin
    int          c0;
    int          first;
    logic        nd;
    logic [23:0] d;
    logic [7:0]  exp_seq[$];

    vecs[0] = '{24'd0,        8'd33, "0",        4'd1, 1'b0};
    vecs[1] = '{24'd12345678, 8'd26, "12345678", 4'd8, 1'b0};
    vecs[2] = '{24'd16777215, 8'd26, "16777215", 4'd8, 1'b1};
    vecs[3] = '{24'd9,        8'd33, "9",        4'd1, 1'b0};
    vecs[4] = '{24'd1000,     8'd30, "1000",     4'd4, 1'b0};
    vecs[5] = '{24'd42,       8'd32, "42",       4'd2, 1'b1};
    vecs[6] = '{24'd10000000, 8'd26, "10000000", 4'd8, 1'b0};
    vecs[7] = '{24'd100,      8'd31, "100",      4'd3, 1'b0};

    checks = 0;
    errors = 0;
    cyc    = 0;
    ovr_cnt = 0;
    last_xfer_cyc = 0;
    model_reset();
    io.new_data   = 1'b0;
    io.data       = '0;
    io.byte_ready = 1'b0;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", io.byte_valid, 0);
    chk("reset_data", io.byte_data, 0);
    chk("reset_busy", io.busy, 0);
    chk("reset_overrun", io.overrun, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Pending overwrite: 42 arrives during CONVERT, 1000 during a stalled EMIT.
    got.delete();
    ovr_cnt = 0;
    step(1'b1, 24'd5, 1'b1);
    repeat (3) step(1'b0, 24'd0, 1'b1);
    step(1'b1, 24'd42, 1'b1);
    for (int k = 0; k < 100 && !io.byte_valid; k++) step(1'b0, 24'd0, 1'b0);
    step(1'b1, 24'd1000, 1'b0);
    run_until_idle(300);
    chk("overrun_pulses", ovr_cnt, 1);
    exp_seq = '{8'h35, 8'h0D, 8'h0A, 8'h31, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    chk_got("overrun_seq", exp_seq);

    // New answer in the LF transfer cycle goes straight back into conversion.
    got.delete();
    ovr_cnt = 0;
    c0 = -1;
    step(1'b1, 24'd12, 1'b1);
    for (int k = 0; k < 100 && c0 < 0; k++) begin
      if (io.byte_valid && io.byte_data == 8'h0A) begin
        c0 = cyc;
        step(1'b1, 24'd77, 1'b1);
      end else begin
        step(1'b0, 24'd0, 1'b1);
      end
    end
    chk("lf_busy_kept", io.busy, 1);
    first = -1;
    for (int k = 0; k < 100 && first < 0; k++) begin
      if (io.byte_valid) first = cyc - c0;
      else step(1'b0, 24'd0, 1'b1);
    end
    chk("lf_refill_latency", first, 32);
    run_until_idle(100);
    chk("lf_refill_overrun", ovr_cnt, 0);
    exp_seq = '{8'h31, 8'h32, 8'h0D, 8'h0A, 8'h37, 8'h37, 8'h0D, 8'h0A};
    chk_got("lf_refill_seq", exp_seq);

    // Reset in the middle of a printed line.
    got.delete();
    step(1'b1, 24'd12345678, 1'b1);
    for (int k = 0; k < 100 && got.size() < 3; k++) step(1'b0, 24'd0, 1'b1);
    reset = 1'b0;
    #1;
    chk("midreset_valid", io.byte_valid, 0);
    chk("midreset_data", io.byte_data, 0);
    chk("midreset_busy", io.busy, 0);
    chk("midreset_overrun", io.overrun, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    step(1'b1, 24'd9, 1'b1);
    run_until_idle(100);
    exp_seq = '{8'h39, 8'h0D, 8'h0A};
    chk_got("after_reset_seq", exp_seq);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      nd = ($urandom % 30 == 0);
      case ($urandom % 4)
        0:       d = 24'($urandom_range(0, 9));
        1:       d = 24'($urandom_range(0, 999));
        2:       d = 24'($urandom);
        default: d = 24'd16777215;
      endcase
      step(nd, d, ($urandom % 4) != 0);
    end
    io.new_data = 1'b0;
    run_until_idle(600);
    chk("model_queue_empty", m_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
